// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter.
// The WB stage and a buffered divider FIFO share one write port. WB normally
// wins. Divider results drain into cycles where WB does not write. A
// starvation counter forces a drain after MAX_WAIT denied cycles.
module rf_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic        wb_ready,
  input  logic        div_valid,
  input  logic [4:0]  div_dest,
  input  logic [31:0] div_data,
  input  logic [31:0] div_pc,
  output logic        div_ready,
  output logic [40:0] wb_to_regfile_bus,
  output logic [31:0] pend_mask,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] SAT_CNT  = SW'(MAX_WAIT);

  logic [4:0]       mem_dest_q [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];
  logic [31:0]      mem_pc_q   [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [31:0]      pend_q, pend_d;

  logic        wb_wr, fifo_grant, push, pop, granted;
  logic [4:0]  sel_dest;
  logic [31:0] sel_data, sel_pc;
  logic [3:0]  rf_we;

  assign wb_wr      = wb_valid && wb_we;
  assign div_ready  = (count_q != FULL_CNT);
  assign push       = div_valid && div_ready;
  assign fifo_grant = (count_q != '0) && (!wb_wr || starve_q == SAT_CNT);
  assign pop        = fifo_grant;
  assign wb_ready   = !(fifo_grant && wb_wr);

  // Port select: the FIFO head when granted, otherwise the WB fields.
  always_comb begin
    sel_dest = wb_dest;
    sel_data = wb_data;
    sel_pc   = wb_pc;
    granted  = wb_wr;
    if (fifo_grant) begin
      sel_dest = mem_dest_q[rd_ptr_q];
      sel_data = mem_data_q[rd_ptr_q];
      sel_pc   = mem_pc_q[rd_ptr_q];
      // r0 is never really written; the entry still retires.
      granted  = (mem_dest_q[rd_ptr_q] != 5'd0);
    end
  end

  // rf_we is forced low while reset is asserted, ahead of any clock edge.
  assign rf_we             = {4{granted && resetn}};
  assign wb_to_regfile_bus = {rf_we, sel_dest, sel_data};
  assign debug_wb_pc       = sel_pc;
  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = sel_dest;
  assign debug_wb_rf_wdata = sel_data;
  assign pend_mask         = pend_q;

  // Next-state for pointers, occupancy, starvation counter and pending mask.
  always_comb begin
    logic [4:0] dn;
    dn       = '0;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (!push && pop) count_d = count_q - CW'(1);

    starve_d = starve_q;
    if (pop || count_q == '0)  starve_d = '0;
    else if (starve_q != SAT_CNT) starve_d = starve_q + SW'(1);

    valid_d = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;

    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dn = (push && wr_ptr_q == AW'(i)) ? div_dest : mem_dest_q[i];
      if (valid_d[i]) pend_d = pend_d | (32'd1 << dn);
    end
    pend_d[0] = 1'b0;
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      valid_q  <= '0;
      pend_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
    end
  end

  // FIFO payload storage; contents are meaningless until marked valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dest_q[wr_ptr_q] <= div_dest;
      mem_data_q[wr_ptr_q] <= div_data;
      mem_pc_q[wr_ptr_q]   <= div_pc;
    end
  end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the pipeline WB stage and a multi-cycle divide unit.
- WB results are written in their retire cycle. Divider results are buffered in a small FIFO and drained into idle port cycles.
- A starvation counter forces a FIFO drain when WB monopolises the port.
- Sits between wb, the divider and the regfile. It drives the regfile write bus and the trace debug interface, and gives ID a pending-destination mask for interlock.

Parameters:
- DEPTH, 2, divider result FIFO entries; power of 2, at least 2.
- MAX_WAIT, 4, WB-write cycles a non-empty FIFO may be denied before a forced drain; at least 1.

Ports:
- clk  in  1  clock; all state on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  WB holds a retiring instruction.
- wb_we  in  1  the WB instruction writes a GPR.
- wb_dest  in  5  WB destination register.
- wb_data  in  32  WB result.
- wb_pc  in  32  WB pc.
- wb_ready  out  1  WB may retire this cycle; WB holds its instruction while 0.
- div_valid  in  1  divider result available.
- div_dest  in  5  divider destination register.
- div_data  in  32  divider result.
- div_pc  in  32  divider instruction pc.
- div_ready  out  1  FIFO accepts a result this cycle.
- wb_to_regfile_bus  out  41  {rf_we[3:0], dest[4:0], data[31:0]}.
- pend_mask  out  32  bit r set while any FIFO entry targets register r.
- debug_wb_pc  out  32  pc of the granted write.
- debug_wb_rf_we  out  4  copy of rf_we.
- debug_wb_rf_wnum  out  5  copy of dest.
- debug_wb_rf_wdata  out  32  copy of data.

Behaviour:
- State: FIFO storage, wr_ptr, rd_ptr, count (0..DEPTH), starve_cnt (0..MAX_WAIT).
- resetn low, asynchronous: pointers, count, starve_cnt and pend_mask clear to 0; FIFO contents are discarded. Outputs follow combinationally.
  - rf_we = 0.
  - div_ready = 1.
  - wb_ready = 1.
  - debug_wb_pc = wb_pc.
- Push: div_valid && div_ready. div_ready = (count != DEPTH), from registered count only; a full FIFO refuses a push even while popping.
- Accepted entries become visible at the FIFO head no earlier than the next cycle; there is no bypass. Divider-to-regfile latency is at least 1 cycle.
- wb_wr = wb_valid && wb_we.
- fifo_grant = (count != 0) && (!wb_wr || starve_cnt == MAX_WAIT).
- Port select:
  - fifo_grant: port carries the head entry and the head is popped.
  - else wb_wr: port carries the WB write.
  - else: rf_we = 0, dest/data = WB fields, pc = wb_pc.
- rf_we = {4{granted write}}. A head entry with dest 0 pops with rf_we = 0.
- wb_ready = !(fifo_grant && wb_wr). A non-writing WB instruction retires even while the FIFO drains.
- starve_cnt:
  - 0 on a pop or when count = 0.
  - +1 when count != 0 and the WB write is granted.
  - Saturates at MAX_WAIT.
- Simultaneous push and pop: count unchanged; pointers each advance mod DEPTH.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; count disambiguates full from empty.
- pend_mask: OR over valid entries of the one-hot dest, registered and updated with push/pop in the same edge. Bit 0 is never set.
- Same-destination ordering between the FIFO and WB is not resolved here; ID interlocks on pend_mask.

Test Plan:
- Reset, then idle inputs -> bus = 0, wb_ready = 1, div_ready = 1, pend_mask = 0; resetn pulse mid-drain -> count = 0 and rf_we = 0 immediately, before the next edge.
- WB write r5 = 0x1234, FIFO empty -> rf_we = 0xF, dest = 5, data = 0x1234 same cycle; wb_ready = 1; debug_wb_pc = wb_pc.
- Divider push r7 = 0xAAAA while WB idle -> pend_mask[7] = 1 next cycle; written the cycle after accept; pend_mask clears after the pop edge.
- Two pushes (r8, r9), DEPTH = 2 -> div_ready = 0 while full; continuous WB writes for 4 cycles -> 5th cycle FIFO granted, r8 written, wb_ready = 0, starve_cnt = 0; r9 waits another 4 WB writes.
- FIFO full and popping, div_valid held -> push refused that cycle, accepted next; 8 push/pop cycles -> pointer wrap, in-order data.
- Head entry dest 0 while WB sends a non-writing instruction -> pop with rf_we = 0, wb_ready = 1, starve_cnt = 0.
